// File: rtl/id_pkg.sv
// id_pkg: opcode map, EXE command/branch encodings and the opcode decoder
// shared by id_exe_stage and its register file.
package id_pkg;

    localparam int REG_AW = 5;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_SUB  = 6'h01;
    localparam logic [5:0] OP_JMP  = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_AND  = 6'h10;
    localparam logic [5:0] OP_OR   = 6'h11;
    localparam logic [5:0] OP_XOR  = 6'h12;
    localparam logic [5:0] OP_SLT  = 6'h13;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    typedef enum logic [3:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_AND = 4'd3,
        CMD_OR  = 4'd4,
        CMD_XOR = 4'd5,
        CMD_SLT = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_EQ   = 2'd1,
        BR_NE   = 2'd2,
        BR_JMP  = 2'd3
    } br_e;

    typedef struct packed {
        logic [3:0] cmd;
        logic [1:0] br;
        logic       mem_read;
        logic       mem_write;
        logic       wb_en;
        logic       is_imm;
    } dec_t;

    // Unknown opcodes decode to an all-zero control word, i.e. a harmless NOP.
    function automatic dec_t decode(input logic [5:0] op);
        dec_t d;
        d = '0;
        case (op)
            OP_ADD:  d = '{CMD_ADD, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0};
            OP_SUB:  d = '{CMD_SUB, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0};
            OP_AND:  d = '{CMD_AND, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0};
            OP_OR:   d = '{CMD_OR,  BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0};
            OP_XOR:  d = '{CMD_XOR, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0};
            OP_SLT:  d = '{CMD_SLT, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0};
            OP_ADDI: d = '{CMD_ADD, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b1};
            OP_ANDI: d = '{CMD_AND, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b1};
            OP_ORI:  d = '{CMD_OR,  BR_NONE, 1'b0, 1'b0, 1'b1, 1'b1};
            OP_LW:   d = '{CMD_ADD, BR_NONE, 1'b1, 1'b0, 1'b1, 1'b1};
            OP_SW:   d = '{CMD_ADD, BR_NONE, 1'b0, 1'b1, 1'b0, 1'b1};
            OP_BEQ:  d = '{CMD_SUB, BR_EQ,   1'b0, 1'b0, 1'b0, 1'b1};
            OP_BNE:  d = '{CMD_SUB, BR_NE,   1'b0, 1'b0, 1'b0, 1'b1};
            OP_JMP:  d = '{CMD_NOP, BR_JMP,  1'b0, 1'b0, 1'b0, 1'b1};
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_exe_stage_regfile.sv
// id_regfile: REG_N x DATA_W register file, two read ports and one write port,
// R0 hardwired to zero; WB_BYPASS_EN adds same-cycle write-through on reads.
module id_regfile
    import id_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_N  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    logic [DATA_W-1:0] mem_q [REG_N];
    logic [DATA_W-1:0] mem_d [REG_N];

    always_comb begin
        mem_d = mem_q;
        if (we && wa != '0)
            mem_d[wa] = wd;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_N; i++)
                mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

`ifdef WB_BYPASS_EN
    assign rd1 = (ra1 == '0) ? '0 : (we && wa == ra1) ? wd : mem_q[ra1];
    assign rd2 = (ra2 == '0) ? '0 : (we && wa == ra2) ? wd : mem_q[ra2];
`else
    assign rd1 = (ra1 == '0) ? '0 : mem_q[ra1];
    assign rd2 = (ra2 == '0) ? '0 : mem_q[ra2];
`endif

endmodule

// File: rtl/id_exe_stage.sv
// id_exe_stage: decode, register read, load-use hazard detection and the ID/EXE
// pipeline register. Define WB_BYPASS_EN for same-cycle WB write-through reads.
module id_exe_stage
    import id_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_N  = 32,
    parameter int IMM_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] pc,
    input  logic              if_valid,
    input  logic              flush,
    input  logic              exe_stall,
    input  logic              ext_freeze,
    input  logic              wb_write_enable,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_result,
    output logic              id_ready,
    output logic              exe_valid,
    output logic [3:0]        exe_cmd,
    output logic              exe_mem_read,
    output logic              exe_mem_write,
    output logic              exe_wb_en,
    output logic [1:0]        exe_br_type,
    output logic [DATA_W-1:0] exe_alu_inp1,
    output logic [DATA_W-1:0] exe_alu_inp2,
    output logic [DATA_W-1:0] exe_reg2,
    output logic [REG_AW-1:0] exe_dest,
    output logic              exe_is_imm,
    output logic [DATA_W-1:0] exe_pc
);

    logic [REG_AW-1:0] src1, src2, rd;
    logic [DATA_W-1:0] rdata1, rdata2, imm_ext;
    dec_t              dec;
    logic              src2_used, hazard, freeze, hold, load;

    logic              valid_q, valid_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [1:0]        br_q, br_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              wb_en_q, wb_en_d;
    logic              is_imm_q, is_imm_d;
    logic [DATA_W-1:0] alu1_q, alu1_d;
    logic [DATA_W-1:0] alu2_q, alu2_d;
    logic [DATA_W-1:0] reg2_q, reg2_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] pc_q, pc_d;

    assign src1    = instruction[25:21];
    assign src2    = instruction[20:16];
    assign rd      = instruction[15:11];
    assign dec     = decode(instruction[31:26]);
    assign imm_ext = {{(DATA_W-IMM_W){instruction[IMM_W-1]}}, instruction[IMM_W-1:0]};

    id_regfile #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N)
    ) u_regfile (
        .clock (clock),
        .reset (reset),
        .ra1   (src1),
        .ra2   (src2),
        .we    (wb_write_enable),
        .wa    (wb_dest),
        .wd    (wb_result),
        .rd1   (rdata1),
        .rd2   (rdata2)
    );

    // Flush outranks stall: a squashed slot must not survive a held EXE stage.
    always_comb begin
        src2_used   = !dec.is_imm || dec.mem_write || dec.br != BR_NONE;
        hazard      = valid_q && mem_read_q && dest_q != '0 && if_valid &&
                      (dest_q == src1 || (src2_used && dest_q == src2));
        freeze      = hazard || ext_freeze;
        hold        = !flush && exe_stall;
        load        = !flush && !exe_stall && !freeze && if_valid;
        valid_d     = hold ? valid_q     : load;
        cmd_d       = hold ? cmd_q       : load ? dec.cmd       : '0;
        br_d        = hold ? br_q        : load ? dec.br        : '0;
        mem_read_d  = hold ? mem_read_q  : load && dec.mem_read;
        mem_write_d = hold ? mem_write_q : load && dec.mem_write;
        wb_en_d     = hold ? wb_en_q     : load && dec.wb_en;
        is_imm_d    = hold ? is_imm_q    : load && dec.is_imm;
        alu1_d      = hold ? alu1_q      : load ? rdata1 : '0;
        alu2_d      = hold ? alu2_q      : load ? (dec.is_imm ? imm_ext : rdata2) : '0;
        reg2_d      = hold ? reg2_q      : load ? rdata2 : '0;
        dest_d      = hold ? dest_q      : load ? (dec.is_imm ? src2 : rd) : '0;
        pc_d        = hold ? pc_q        : load ? pc : '0;
    end

    assign id_ready = !exe_stall && !freeze;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            cmd_q       <= '0;
            br_q        <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            wb_en_q     <= 1'b0;
            is_imm_q    <= 1'b0;
            alu1_q      <= '0;
            alu2_q      <= '0;
            reg2_q      <= '0;
            dest_q      <= '0;
            pc_q        <= '0;
        end else begin
            valid_q     <= valid_d;
            cmd_q       <= cmd_d;
            br_q        <= br_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            wb_en_q     <= wb_en_d;
            is_imm_q    <= is_imm_d;
            alu1_q      <= alu1_d;
            alu2_q      <= alu2_d;
            reg2_q      <= reg2_d;
            dest_q      <= dest_d;
            pc_q        <= pc_d;
        end
    end

    assign exe_valid     = valid_q;
    assign exe_cmd       = cmd_q;
    assign exe_br_type   = br_q;
    assign exe_mem_read  = mem_read_q;
    assign exe_mem_write = mem_write_q;
    assign exe_wb_en     = wb_en_q;
    assign exe_is_imm    = is_imm_q;
    assign exe_alu_inp1  = alu1_q;
    assign exe_alu_inp2  = alu2_q;
    assign exe_reg2      = reg2_q;
    assign exe_dest      = dest_q;
    assign exe_pc        = pc_q;

endmodule

// File: tb/tb_id_exe_stage.sv
// tb_id_exe_stage: decode vector table, directed pipeline corner cases and a
// randomized run against a behavioural model of the decode stage.
module tb_id_exe_stage;
    import id_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instruction, pc, wb_result;
    logic        if_valid, flush, exe_stall, ext_freeze, wb_write_enable;
    logic [4:0]  wb_dest;
    logic        id_ready, exe_valid, exe_mem_read, exe_mem_write, exe_wb_en, exe_is_imm;
    logic [3:0]  exe_cmd;
    logic [1:0]  exe_br_type;
    logic [31:0] exe_alu_inp1, exe_alu_inp2, exe_reg2, exe_pc;
    logic [4:0]  exe_dest;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    id_exe_stage dut (
        .clock(clock), .reset(reset), .instruction(instruction), .pc(pc),
        .if_valid(if_valid), .flush(flush), .exe_stall(exe_stall), .ext_freeze(ext_freeze),
        .wb_write_enable(wb_write_enable), .wb_dest(wb_dest), .wb_result(wb_result),
        .id_ready(id_ready), .exe_valid(exe_valid), .exe_cmd(exe_cmd),
        .exe_mem_read(exe_mem_read), .exe_mem_write(exe_mem_write), .exe_wb_en(exe_wb_en),
        .exe_br_type(exe_br_type), .exe_alu_inp1(exe_alu_inp1), .exe_alu_inp2(exe_alu_inp2),
        .exe_reg2(exe_reg2), .exe_dest(exe_dest), .exe_is_imm(exe_is_imm), .exe_pc(exe_pc)
    );

    typedef struct packed {
        logic [3:0] cmd;
        logic [1:0] br;
        logic       mr, mw, wb, imm;
    } ctl_t;

    typedef struct packed {
        logic        v;
        ctl_t        c;
        logic [31:0] a, b, s;
        logic [4:0]  d;
        logic [31:0] p;
    } exe_t;

    typedef struct {
        logic [31:0] ins;
        ctl_t        c;
        logic [4:0]  d;
        logic [31:0] a, b, s;
    } vec_t;

    logic [31:0] rf [32];
    exe_t        m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        instruction = '0; pc = '0; if_valid = 0; flush = 0;
        exe_stall = 0; ext_freeze = 0; wb_write_enable = 0; wb_dest = '0; wb_result = '0;
    endtask

    task automatic wb_write(input logic [4:0] d, input logic [31:0] v);
        idle;
        wb_write_enable = 1; wb_dest = d; wb_result = v;
        tick;
        wb_write_enable = 0;
    endtask

    // Reference instruction-set table: what each opcode means to the EXE stage.
    function automatic ctl_t ref_ctl(input logic [5:0] op);
        case (op)
            OP_ADD:  return '{CMD_ADD, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0};
            OP_SUB:  return '{CMD_SUB, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0};
            OP_AND:  return '{CMD_AND, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0};
            OP_OR:   return '{CMD_OR,  BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0};
            OP_XOR:  return '{CMD_XOR, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0};
            OP_SLT:  return '{CMD_SLT, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0};
            OP_ADDI: return '{CMD_ADD, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b1};
            OP_ANDI: return '{CMD_AND, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b1};
            OP_ORI:  return '{CMD_OR,  BR_NONE, 1'b0, 1'b0, 1'b1, 1'b1};
            OP_LW:   return '{CMD_ADD, BR_NONE, 1'b1, 1'b0, 1'b1, 1'b1};
            OP_SW:   return '{CMD_ADD, BR_NONE, 1'b0, 1'b1, 1'b0, 1'b1};
            OP_BEQ:  return '{CMD_SUB, BR_EQ,   1'b0, 1'b0, 1'b0, 1'b1};
            OP_BNE:  return '{CMD_SUB, BR_NE,   1'b0, 1'b0, 1'b0, 1'b1};
            OP_JMP:  return '{CMD_NOP, BR_JMP,  1'b0, 1'b0, 1'b0, 1'b1};
            default: return '0;
        endcase
    endfunction

    function automatic logic [31:0] rf_read(input logic [4:0] r);
        if (r == 0) return 0;
`ifdef WB_BYPASS_EN
        if (wb_write_enable && wb_dest == r) return wb_result;
`endif
        return rf[r];
    endfunction

    task automatic chk_outs(input string tag, input exe_t e);
        chk({tag, " ctl"}, {exe_valid, exe_cmd, exe_br_type, exe_mem_read, exe_mem_write, exe_wb_en, exe_is_imm},
            {e.v, e.c});
        if (e.v) begin
            chk({tag, " inp1"}, exe_alu_inp1, e.a);
            chk({tag, " inp2"}, exe_alu_inp2, e.b);
            chk({tag, " reg2"}, exe_reg2, e.s);
            chk({tag, " dest"}, exe_dest, e.d);
            chk({tag, " pc"}, exe_pc, e.p);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[12];
        logic [5:0]  ops[15];
        logic [5:0]  op;
        logic [4:0]  rs, rt, rdf;
        logic [31:0] imm, a, b;
        logic        used, haz;
        ctl_t        c;

        tbl[0]  = '{32'h2022_0005, '{CMD_ADD, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b1}, 5'd2, 32'h10, 32'h5,        32'h22};
        tbl[1]  = '{32'h2022_FFFC, '{CMD_ADD, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b1}, 5'd2, 32'h10, 32'hFFFF_FFFC, 32'h22};
        tbl[2]  = '{32'h0022_2000, '{CMD_ADD, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0}, 5'd4, 32'h10, 32'h22,       32'h22};
        tbl[3]  = '{32'h0461_2800, '{CMD_SUB, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0}, 5'd5, 32'h33, 32'h10,       32'h10};
        tbl[4]  = '{32'h8C23_0004, '{CMD_ADD, BR_NONE, 1'b1, 1'b0, 1'b1, 1'b1}, 5'd3, 32'h10, 32'h4,        32'h33};
        tbl[5]  = '{32'hAC43_0008, '{CMD_ADD, BR_NONE, 1'b0, 1'b1, 1'b0, 1'b1}, 5'd3, 32'h22, 32'h8,        32'h33};
        tbl[6]  = '{32'h1022_FFFF, '{CMD_SUB, BR_EQ,   1'b0, 1'b0, 1'b0, 1'b1}, 5'd2, 32'h10, 32'hFFFF_FFFF, 32'h22};
        tbl[7]  = '{32'h3466_8000, '{CMD_OR,  BR_NONE, 1'b0, 1'b0, 1'b1, 1'b1}, 5'd6, 32'h33, 32'hFFFF_8000, 32'h0};
        tbl[8]  = '{32'hFC22_0000, '{CMD_NOP, BR_NONE, 1'b0, 1'b0, 1'b0, 1'b0}, 5'd0, 32'h10, 32'h22,       32'h22};
        tbl[9]  = '{32'h0800_0010, '{CMD_NOP, BR_JMP,  1'b0, 1'b0, 1'b0, 1'b1}, 5'd0, 32'h0,  32'h10,       32'h0};
        tbl[10] = '{32'h3047_00F0, '{CMD_AND, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b1}, 5'd7, 32'h22, 32'hF0,       32'h0};
        tbl[11] = '{32'h4C62_4800, '{CMD_SLT, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0}, 5'd9, 32'h33, 32'h22,       32'h22};
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_ADDI, OP_ANDI,
                OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JMP, 6'h3F};

        idle;
        reset = 1;
        #2;
        chk_outs("reset", '0);
        chk("reset data", {exe_alu_inp1, exe_alu_inp2} | {exe_reg2, exe_pc} | 64'(exe_dest), 0);
        tick;
        reset = 0;

        wb_write(5'd1, 32'h10);
        wb_write(5'd2, 32'h22);
        wb_write(5'd3, 32'h33);
        for (int i = 0; i < 12; i++) begin
            idle;
            instruction = tbl[i].ins; pc = 32'h100 + 32'(i * 4); if_valid = 1;
            tick;
            chk_outs($sformatf("vec%0d", i),
                     '{1'b1, tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].d, 32'h100 + 32'(i * 4)});
            idle;
            tick;
        end

        // Load-use: LW r3 followed by ADD reading r3 costs one bubble.
        idle;
        instruction = 32'h8C23_0000; if_valid = 1;
        tick;
        instruction = 32'h0063_2020; pc = 32'h204;
        #1 chk("loaduse ready0", id_ready, 0);
        tick;
        chk("loaduse bubble", {exe_valid, exe_wb_en}, 0);
        chk("loaduse ready1", id_ready, 1);
        tick;
        chk_outs("loaduse add", '{1'b1, '{CMD_ADD, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0},
                 32'h33, 32'h33, 32'h33, 5'd4, 32'h204});

        // Stall holds EXE for three cycles, then flush during stall squashes it.
        idle;
        instruction = 32'h2022_0005; pc = 32'h300; if_valid = 1;
        tick;
        instruction = 32'h0461_2800; exe_stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall ready", id_ready, 0);
            tick;
            chk_outs("stall hold", '{1'b1, '{CMD_ADD, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b1},
                     32'h10, 32'h5, 32'h22, 5'd2, 32'h300});
        end
        flush = 1;
        tick;
        chk("flush+stall", {exe_valid, exe_wb_en, exe_cmd}, 0);

        // External freeze inserts a bubble.
        idle;
        instruction = 32'h2022_0005; if_valid = 1; ext_freeze = 1;
        #1 chk("freeze ready", id_ready, 0);
        tick;
        chk("freeze bubble", {exe_valid, exe_wb_en}, 0);

        // Writes to r0 are discarded.
        wb_write(5'd0, 32'hDEAD);
        idle;
        instruction = 32'h2000_0000; if_valid = 1;
        tick;
        chk("r0 read", exe_alu_inp1, 0);

        // Same-cycle WB write and read of r5.
        wb_write(5'd5, 32'h1111);
        idle;
        instruction = 32'h20A0_0000; if_valid = 1;
        wb_write_enable = 1; wb_dest = 5'd5; wb_result = 32'hABCD;
        tick;
`ifdef WB_BYPASS_EN
        chk("wb same cycle", exe_alu_inp1, 32'hABCD);
`else
        chk("wb same cycle", exe_alu_inp1, 32'h1111);
`endif
        wb_write_enable = 0;
        tick;
        chk("wb next cycle", exe_alu_inp1, 32'hABCD);

        // Asynchronous reset while EXE is valid.
        idle;
        instruction = 32'h2022_0005; if_valid = 1;
        tick;
        chk("pre-reset valid", exe_valid, 1);
        reset = 1;
        #1 chk_outs("async reset", '0);
        tick;
        reset = 0;
        tick;
        chk("post-reset rf", exe_alu_inp1, 0);

        // Randomized run against the model.
        for (int i = 0; i < 32; i++) rf[i] = 0;
        m = '0;
        idle;
        reset = 1;
        tick;
        reset = 0;
        for (int n = 0; n < 400; n++) begin
            op  = ops[$urandom_range(0, 14)];
            rs  = 5'($urandom_range(0, 7));
            rt  = 5'($urandom_range(0, 7));
            rdf = 5'($urandom_range(0, 7));
            instruction     = {op, rs, rt, rdf, 11'($urandom)};
            pc              = $urandom;
            if_valid        = ($urandom % 5) != 0;
            flush           = ($urandom % 8) == 0;
            exe_stall       = ($urandom % 6) == 0;
            ext_freeze      = ($urandom % 8) == 0;
            wb_write_enable = $urandom % 2;
            wb_dest         = 5'($urandom_range(0, 7));
            wb_result       = $urandom;
            c    = ref_ctl(op);
            imm  = {{16{instruction[15]}}, instruction[15:0]};
            a    = rf_read(rs);
            b    = rf_read(rt);
            used = !c.imm || c.mw || c.br != 0;
            haz  = m.v && m.c.mr && m.d != 0 && (m.d == rs || (used && m.d == rt)) && if_valid;
            #1 chk("rnd id_ready", id_ready, !exe_stall && !haz && !ext_freeze);
            if (flush) m = '0;
            else if (!exe_stall) m = (haz || ext_freeze || !if_valid) ? '0 :
                '{1'b1, c, a, c.imm ? imm : b, b, c.imm ? rt : rdf, pc};
            if (wb_write_enable && wb_dest != 0) rf[wb_dest] = wb_result;
            tick;
            chk_outs("rnd", m);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
